// File: rtl/dg0045_ram_sequencer.sv
//------------------------------------------------------------------------------
// dg0045_ram_sequencer
//
// Initiator-side controller for the DG0045 nibble RAM (2**ADDR_W x DATA_W).
// It takes one request at a time from game logic and drives the RAM's
// address, write data and write strobe. Supported operations are READ,
// WRITE, nibble ADD (read-modify-write with carry out) and CLEAR-ALL.
// The result comes back on a valid/ready response channel.
//
// Every output is a flop. The combinational block computes the next value of
// each output, so all outputs change only on a clock edge or on reset.
//
// Ports
//   RAM_clk    in   1       sole clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   req_valid  in   1       request present
//   req_ready  out  1       sequencer can accept (high only in IDLE)
//   req_op     in   2       00 READ, 01 WRITE, 10 ADD, 11 CLEAR-ALL
//   req_addr   in   ADDR_W  target word (ignored for CLEAR-ALL)
//   req_data   in   DATA_W  write data / addend
//   rsp_valid  out  1       response present, held until rsp_ready
//   rsp_ready  in   1       consumer accepts response
//   rsp_data   out  DATA_W  READ: word read, ADD: sum written, else 0
//   rsp_carry  out  1       ADD: carry out of the sum, else 0
//   ram_addr   out  ADDR_W  RAM address
//   ram_din    out  DATA_W  RAM write data
//   ram_we     out  1       RAM write strobe, one cycle per written word
//   ram_dout   in   DATA_W  RAM asynchronous read data
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module dg0045_ram_sequencer #(
   parameter int unsigned       ADDR_W    = 6,
   parameter int unsigned       DATA_W    = 4,
   parameter logic [DATA_W-1:0] CLEAR_VAL = 4'h0
) (
   input  logic              RAM_clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_carry,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_dout
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RD     = 3'd1,
      S_WR     = 3'd2,
      S_RMW_RD = 3'd3,
      S_RMW_WR = 3'd4,
      S_CLR    = 3'd5,
      S_RESP   = 3'd6
   } state_t;

   localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

   state_t              r_state;
   logic                r_req_ready;
   logic                r_rsp_valid;
   logic [DATA_W-1:0]   r_rsp_data;
   logic                r_rsp_carry;
   logic [ADDR_W-1:0]   r_ram_addr;
   logic [DATA_W-1:0]   r_ram_din;
   logic                r_ram_we;
   logic [ADDR_W-1:0]   r_clr_cnt;
   logic [DATA_W-1:0]   r_data;
   logic [DATA_W:0]     r_sum;

   state_t              w_state_nxt;
   logic                w_req_ready_nxt;
   logic                w_rsp_valid_nxt;
   logic [DATA_W-1:0]   w_rsp_data_nxt;
   logic                w_rsp_carry_nxt;
   logic [ADDR_W-1:0]   w_ram_addr_nxt;
   logic [DATA_W-1:0]   w_ram_din_nxt;
   logic                w_ram_we_nxt;
   logic [ADDR_W-1:0]   w_clr_cnt_nxt;
   logic [DATA_W-1:0]   w_data_nxt;
   logic [DATA_W:0]     w_sum_nxt;
   logic [DATA_W:0]     w_sum;

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_carry = r_rsp_carry;
   assign ram_addr  = r_ram_addr;
   assign ram_din   = r_ram_din;
   assign ram_we    = r_ram_we;

   // Next-state and next-output logic; every register holds unless a state says otherwise.
   always_comb begin
      w_state_nxt     = r_state;
      w_req_ready_nxt = r_req_ready;
      w_rsp_valid_nxt = r_rsp_valid;
      w_rsp_data_nxt  = r_rsp_data;
      w_rsp_carry_nxt = r_rsp_carry;
      w_ram_addr_nxt  = r_ram_addr;
      w_ram_din_nxt   = r_ram_din;
      w_ram_we_nxt    = 1'b0;
      w_clr_cnt_nxt   = r_clr_cnt;
      w_data_nxt      = r_data;
      w_sum_nxt       = r_sum;
      // Unsigned DATA_W+1 bit sum so the top bit is the carry.
      w_sum           = {1'b0, ram_dout} + {1'b0, r_data};

      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               // The address goes straight into the ram_addr flop, so the
               // RAM is already addressed in the first cycle after accept.
               w_req_ready_nxt = 1'b0;
               w_data_nxt      = req_data;
               w_ram_addr_nxt  = req_addr;
               case (req_op)
                  2'b00: begin
                     w_state_nxt = S_RD;
                  end
                  2'b01: begin
                     w_state_nxt   = S_WR;
                     w_ram_din_nxt = req_data;
                     w_ram_we_nxt  = 1'b1;
                  end
                  2'b10: begin
                     w_state_nxt = S_RMW_RD;
                  end
                  2'b11: begin
                     w_state_nxt    = S_CLR;
                     w_ram_addr_nxt = {ADDR_W{1'b0}};
                     w_ram_din_nxt  = CLEAR_VAL;
                     w_ram_we_nxt   = 1'b1;
                     w_clr_cnt_nxt  = {ADDR_W{1'b0}};
                  end
                  default: begin
                     w_state_nxt     = S_IDLE;
                     w_req_ready_nxt = 1'b1;
                  end
               endcase
            end else begin
               w_state_nxt = S_IDLE;
            end
         end

         S_RD: begin
            w_rsp_data_nxt  = ram_dout;
            w_rsp_carry_nxt = 1'b0;
            w_rsp_valid_nxt = 1'b1;
            w_state_nxt     = S_RESP;
         end

         S_WR: begin
            w_rsp_data_nxt  = {DATA_W{1'b0}};
            w_rsp_carry_nxt = 1'b0;
            w_rsp_valid_nxt = 1'b1;
            w_state_nxt     = S_RESP;
         end

         S_RMW_RD: begin
            w_sum_nxt     = w_sum;
            w_ram_din_nxt = w_sum[DATA_W-1:0];
            w_ram_we_nxt  = 1'b1;
            w_state_nxt   = S_RMW_WR;
         end

         S_RMW_WR: begin
            w_rsp_data_nxt  = r_sum[DATA_W-1:0];
            w_rsp_carry_nxt = r_sum[DATA_W];
            w_rsp_valid_nxt = 1'b1;
            w_state_nxt     = S_RESP;
         end

         S_CLR: begin
            if (r_clr_cnt == CNT_LAST) begin
               // Last word is being written this cycle; counter wraps to 0.
               w_clr_cnt_nxt   = {ADDR_W{1'b0}};
               w_rsp_data_nxt  = {DATA_W{1'b0}};
               w_rsp_carry_nxt = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_state_nxt     = S_RESP;
            end else begin
               w_clr_cnt_nxt  = r_clr_cnt + CNT_ONE;
               w_ram_addr_nxt = r_clr_cnt + CNT_ONE;
               w_ram_we_nxt   = 1'b1;
               w_state_nxt    = S_CLR;
            end
         end

         S_RESP: begin
            if (rsp_ready) begin
               w_rsp_valid_nxt = 1'b0;
               w_req_ready_nxt = 1'b1;
               w_state_nxt     = S_IDLE;
            end else begin
               w_state_nxt = S_RESP;
            end
         end

         default: begin
            w_state_nxt     = S_IDLE;
            w_req_ready_nxt = 1'b1;
            w_rsp_valid_nxt = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any sequence in progress.
   always_ff @(posedge RAM_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= {DATA_W{1'b0}};
         r_rsp_carry <= 1'b0;
         r_ram_addr  <= {ADDR_W{1'b0}};
         r_ram_din   <= {DATA_W{1'b0}};
         r_ram_we    <= 1'b0;
         r_clr_cnt   <= {ADDR_W{1'b0}};
         r_data      <= {DATA_W{1'b0}};
         r_sum       <= {(DATA_W+1){1'b0}};
      end else begin
         r_state     <= w_state_nxt;
         r_req_ready <= w_req_ready_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_data  <= w_rsp_data_nxt;
         r_rsp_carry <= w_rsp_carry_nxt;
         r_ram_addr  <= w_ram_addr_nxt;
         r_ram_din   <= w_ram_din_nxt;
         r_ram_we    <= w_ram_we_nxt;
         r_clr_cnt   <= w_clr_cnt_nxt;
         r_data      <= w_data_nxt;
         r_sum       <= w_sum_nxt;
      end
   end

endmodule

// File: tb/tb_dg0045_ram_sequencer.sv
`timescale 1ns/1ps

module tb_dg0045_ram_sequencer;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 4;

   logic              RAM_clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [1:0]        req_op = 2'd0;
   logic [ADDR_W-1:0] req_addr = 6'd0;
   logic [DATA_W-1:0] req_data = 4'h0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_carry;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic              ram_we;
   logic [DATA_W-1:0] ram_dout;

   int n_tests = 0;
   int n_fail  = 0;

   dg0045_ram_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_VAL(4'h0)) dut (
      .RAM_clk  (RAM_clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_op   (req_op),
      .req_addr (req_addr),
      .req_data (req_data),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_data (rsp_data),
      .rsp_carry(rsp_carry),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_we   (ram_we),
      .ram_dout (ram_dout)
   );

   always #5 RAM_clk = ~RAM_clk;

   // Behavioural 64x4 RAM: asynchronous read, synchronous write.
   logic [DATA_W-1:0] mem [0:63];
   logic              mem_init = 1'b1;
   assign ram_dout = mem[ram_addr];

   always @(posedge RAM_clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= 4'hF;
      end else if (ram_we) begin
         mem[ram_addr] <= ram_din;
      end
   end

   typedef struct {
      logic [1:0] op;
      logic [5:0] addr;
      logic [3:0] data;
      logic [3:0] exp_d;
      logic       exp_c;
      int         exp_lat;
      int         exp_we;
   } vec_t;

   vec_t vecs [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one request, measure latency (falling edges until rsp_valid), count
   // write strobes, optionally stall the response and poke req_valid while busy.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [5:0] a,
                         input logic [3:0] d, input logic [3:0] exp_din, input int hold,
                         input bit pulse, output logic [3:0] gd, output logic gc,
                         output int lat, output int wes);
      int         bad_we;
      int         bad_hold;
      logic [5:0] ea;
      bad_we = 0; bad_hold = 0; lat = 0; wes = 0;
      @(negedge RAM_clk);
      check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_op = op; req_addr = a; req_data = d;
      @(posedge RAM_clk);
      #1;
      req_valid = 1'b0; req_addr = ~a; req_data = ~d;
      while (lat < 200) begin
         @(negedge RAM_clk);
         lat++;
         if (ram_we) begin
            ea = (op == 2'd3) ? wes[5:0] : a;
            if (ram_addr !== ea || ram_din !== exp_din) bad_we++;
            wes++;
         end
         if (rsp_valid) break;
         if (pulse) begin
            req_valid = (lat == 1); req_op = 2'd1; req_addr = 6'd9; req_data = 4'h5;
         end
      end
      req_valid = 1'b0;
      check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
      gd = rsp_data;
      gc = rsp_carry;
      for (int h = 0; h < hold; h++) begin
         req_valid = pulse; req_op = 2'd1; req_addr = 6'd9; req_data = 4'h5;
         @(negedge RAM_clk);
         if (rsp_valid !== 1'b1 || rsp_data !== gd || rsp_carry !== gc || req_ready !== 1'b0)
            bad_hold++;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge RAM_clk);
      #1;
      rsp_ready = 1'b0;
      check({tag, "_done"}, {30'd0, rsp_valid, req_ready}, 32'd1);
      check({tag, "_we_addr_din"}, bad_we, 32'd0);
      if (hold > 0) check({tag, "_hold_stable"}, bad_hold, 32'd0);
   endtask

   initial begin
      logic [3:0] gd;
      logic       gc;
      int         lat;
      int         wes;
      logic [3:0] exp_din;
      int         nz;
      bit         found;

      // op, addr, data, exp rsp_data, exp carry, latency, write strobes
      vecs[0]  = '{2'd1, 6'd5,  4'hA, 4'h0, 1'b0, 2,  1};
      vecs[1]  = '{2'd0, 6'd5,  4'h0, 4'hA, 1'b0, 2,  0};
      vecs[2]  = '{2'd2, 6'd5,  4'h7, 4'h1, 1'b1, 3,  1};
      vecs[3]  = '{2'd0, 6'd5,  4'h0, 4'h1, 1'b0, 2,  0};
      vecs[4]  = '{2'd1, 6'd10, 4'h3, 4'h0, 1'b0, 2,  1};
      vecs[5]  = '{2'd2, 6'd10, 4'h4, 4'h7, 1'b0, 3,  1};
      vecs[6]  = '{2'd2, 6'd10, 4'h9, 4'h0, 1'b1, 3,  1};
      vecs[7]  = '{2'd0, 6'd10, 4'h0, 4'h0, 1'b0, 2,  0};
      vecs[8]  = '{2'd1, 6'd63, 4'hF, 4'h0, 1'b0, 2,  1};
      vecs[9]  = '{2'd0, 6'd63, 4'h0, 4'hF, 1'b0, 2,  0};
      vecs[10] = '{2'd1, 6'd0,  4'h6, 4'h0, 1'b0, 2,  1};
      vecs[11] = '{2'd2, 6'd0,  4'hF, 4'h5, 1'b1, 3,  1};
      vecs[12] = '{2'd3, 6'd33, 4'h9, 4'h0, 1'b0, 65, 64};
      vecs[13] = '{2'd0, 6'd63, 4'h0, 4'h0, 1'b0, 2,  0};
      vecs[14] = '{2'd0, 6'd5,  4'h0, 4'h0, 1'b0, 2,  0};
      vecs[15] = '{2'd0, 6'd0,  4'h0, 4'h0, 1'b0, 2,  0};

      // Reset state
      repeat (2) @(posedge RAM_clk);
      mem_init = 1'b0;
      @(negedge RAM_clk);
      check("reset_outs", {14'd0, req_ready, rsp_valid, rsp_data, rsp_carry, ram_addr, ram_din, ram_we},
            32'h0002_0000);
      rst_n = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < 16; i++) begin
         exp_din = (vecs[i].op == 2'd1) ? vecs[i].data :
                   (vecs[i].op == 2'd2) ? vecs[i].exp_d : 4'h0;
         run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].addr, vecs[i].data, exp_din,
                0, 1'b0, gd, gc, lat, wes);
         check($sformatf("v%0d_data", i), {28'd0, gd}, {28'd0, vecs[i].exp_d});
         check($sformatf("v%0d_carry", i), {31'd0, gc}, {31'd0, vecs[i].exp_c});
         check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
         check($sformatf("v%0d_we_cnt", i), wes, vecs[i].exp_we);
      end
      nz = 0;
      for (int i = 0; i < 64; i++) if (mem[i] !== 4'h0) nz++;
      check("clear_all_zero", nz, 32'd0);

      // Stalled response with req_valid pokes while busy
      run_op("w7", 2'd1, 6'd7, 4'hC, 4'hC, 0, 1'b0, gd, gc, lat, wes);
      run_op("hold_rd", 2'd0, 6'd7, 4'h0, 4'h0, 5, 1'b1, gd, gc, lat, wes);
      check("hold_rd_data", {28'd0, gd}, 32'hC);
      run_op("hold_add", 2'd2, 6'd7, 4'h1, 4'hD, 2, 1'b1, gd, gc, lat, wes);
      check("hold_add_data", {27'd0, gc, gd}, 32'h0D);
      check("hold_add_lat", lat, 32'd3);
      check("busy_no_write", {28'd0, mem[9]}, 32'h0);
      run_op("rd9", 2'd0, 6'd9, 4'h0, 4'h0, 0, 1'b0, gd, gc, lat, wes);
      check("rd9_data", {28'd0, gd}, 32'h0);

      // Reset in the middle of CLEAR-ALL
      run_op("w19", 2'd1, 6'd19, 4'h2, 4'h2, 0, 1'b0, gd, gc, lat, wes);
      run_op("w20", 2'd1, 6'd20, 4'h3, 4'h3, 0, 1'b0, gd, gc, lat, wes);
      run_op("w40", 2'd1, 6'd40, 4'h9, 4'h9, 0, 1'b0, gd, gc, lat, wes);
      @(negedge RAM_clk);
      req_valid = 1'b1; req_op = 2'd3; req_addr = 6'd0; req_data = 4'h0;
      @(posedge RAM_clk);
      #1;
      req_valid = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge RAM_clk);
         if (ram_we === 1'b1 && ram_addr === 6'd20) begin
            found = 1'b1;
            break;
         end
      end
      check("clr_reached_20", {31'd0, found}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_outs", {14'd0, req_ready, rsp_valid, rsp_data, rsp_carry, ram_addr, ram_din, ram_we},
            32'h0002_0000);
      repeat (2) @(negedge RAM_clk);
      check("abort_hold_outs", {14'd0, req_ready, rsp_valid, ram_we}, 32'h4);
      rst_n = 1'b1;
      check("abort_mem19", {28'd0, mem[19]}, 32'h0);
      check("abort_mem20", {28'd0, mem[20]}, 32'h3);
      check("abort_mem40", {28'd0, mem[40]}, 32'h9);
      run_op("rd40", 2'd0, 6'd40, 4'h0, 4'h0, 0, 1'b0, gd, gc, lat, wes);
      check("rd40_data", {28'd0, gd}, 32'h9);
      check("rd40_lat", lat, 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
